// File: rtl/inst_fetch_queue.sv
// Instruction queue between the I-cache and a dual-issue decoder.
// Accepts one or two sequential instructions per cycle and presents the two oldest.
module inst_fetch_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_valid,
  input  logic [31:0]      push_pc,
  input  logic [31:0]      push_inst,
  input  logic [31:0]      push_inst2,
  input  logic             push_inst2_v,
  output logic             push_ready,
  input  logic [1:0]       pop_cnt,
  output logic             out0_valid,
  output logic [31:0]      out0_pc,
  output logic [31:0]      out0_inst,
  output logic             out1_valid,
  output logic [31:0]      out1_pc,
  output logic [31:0]      out1_inst,
  output logic [PTR_W:0]   count_o
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] TWO_C   = (PTR_W+1)'(2);

  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];

  logic [PTR_W-1:0] head_reg, head_next, head_p1;
  logic [PTR_W-1:0] tail_reg, tail_next, tail_p1;
  logic [PTR_W:0]   count_reg, count_next;
  logic [PTR_W:0]   push_n, pop_req, pop_n;
  logic             push_acc;
  logic [DEPTH-1:0] wr_lo, wr_hi;
  logic [31:0]      pc_plus4;

  assign push_ready = (count_reg <= DEPTH_C - TWO_C);
  assign push_acc   = push_valid & push_ready & ~flush;
  assign head_p1    = head_reg + PTR_W'(1);
  assign tail_p1    = tail_reg + PTR_W'(1);
  assign pc_plus4   = push_pc + 32'd4;
  assign count_o    = count_reg;

  // pop_cnt of 3 behaves as 2; pops are clipped to the current occupancy
  assign pop_req = {{(PTR_W-1){1'b0}}, pop_cnt[1], pop_cnt[0] & ~pop_cnt[1]};
  assign pop_n   = (pop_req > count_reg) ? count_reg : pop_req;

  always_comb begin
    push_n = '0;
    if (push_acc) begin
      push_n = {{(PTR_W-1){1'b0}}, push_inst2_v, ~push_inst2_v};
    end
  end

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      head_next  = head_reg + pop_n[PTR_W-1:0];
      tail_next  = tail_reg + push_n[PTR_W-1:0];
      count_next = count_reg + push_n - pop_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Per-entry write enables: primary lands at tail, the PC+4 companion at tail+1
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_lo[gi] = push_acc && (tail_reg == PTR_W'(gi));
      assign wr_hi[gi] = push_acc && push_inst2_v && (tail_p1 == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_lo[i]) begin
          pc_mem[i]   <= push_pc;
          inst_mem[i] <= push_inst;
        end else if (wr_hi[i]) begin
          pc_mem[i]   <= pc_plus4;
          inst_mem[i] <= push_inst2;
        end
      end
    end
  end

  always_comb begin
    out0_valid = 1'b0;
    out0_pc    = '0;
    out0_inst  = '0;
    out1_valid = 1'b0;
    out1_pc    = '0;
    out1_inst  = '0;
    if (count_reg != '0) begin
      out0_valid = 1'b1;
      out0_pc    = pc_mem[head_reg];
      out0_inst  = inst_mem[head_reg];
    end
    if (count_reg >= TWO_C) begin
      out1_valid = 1'b1;
      out1_pc    = pc_mem[head_p1];
      out1_inst  = inst_mem[head_p1];
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: directed scenarios then random traffic,
// checked against a queue-of-entries reference model.
module tb_inst_fetch_queue;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             push_valid = 1'b0;
  logic [31:0]      push_pc = '0;
  logic [31:0]      push_inst = '0;
  logic [31:0]      push_inst2 = '0;
  logic             push_inst2_v = 1'b0;
  logic             push_ready;
  logic [1:0]       pop_cnt = '0;
  logic             out0_valid, out1_valid;
  logic [31:0]      out0_pc, out0_inst, out1_pc, out1_inst;
  logic [PTR_W:0]   count_o;

  inst_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_pc(push_pc), .push_inst(push_inst),
    .push_inst2(push_inst2), .push_inst2_v(push_inst2_v), .push_ready(push_ready),
    .pop_cnt(pop_cnt),
    .out0_valid(out0_valid), .out0_pc(out0_pc), .out0_inst(out0_inst),
    .out1_valid(out1_valid), .out1_pc(out1_pc), .out1_inst(out1_inst),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  typedef struct {
    int          cnt;
    bit          rdy;
    bit          v0;
    logic [31:0] pc0, i0;
    bit          v1;
    logic [31:0] pc1, i1;
  } exp_t;

  entry_t model_q[$];
  exp_t   exp_q[$];
  int     tail_mod = 0;
  int     total = 0;
  int     bad = 0;
  int     txn = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.cnt = model_q.size();
    e.rdy = (DEPTH - model_q.size()) >= 2;
    e.v0  = model_q.size() >= 1;
    e.pc0 = e.v0 ? model_q[0].pc   : 32'h0;
    e.i0  = e.v0 ? model_q[0].inst : 32'h0;
    e.v1  = model_q.size() >= 2;
    e.pc1 = e.v1 ? model_q[1].pc   : 32'h0;
    e.i1  = e.v1 ? model_q[1].inst : 32'h0;
    return e;
  endfunction

  // Drive one cycle of stimulus, apply it to the model at the edge, queue the expectation.
  task automatic step(input bit f, input bit pv, input logic [31:0] pc, input logic [31:0] i1,
                      input logic [31:0] i2, input bit i2v, input logic [1:0] pc_n);
    int old_size;
    int pn;
    flush = f; push_valid = pv; push_pc = pc; push_inst = i1;
    push_inst2 = i2; push_inst2_v = i2v; pop_cnt = pc_n;
    @(posedge clk);
    old_size = model_q.size();
    if (f) begin
      model_q.delete();
      tail_mod = 0;
    end else begin
      pn = (pc_n > 2) ? 2 : int'(pc_n);
      if (pn > old_size) pn = old_size;
      repeat (pn) void'(model_q.pop_front());
      if (pv && (DEPTH - old_size) >= 2) begin
        model_q.push_back('{pc, i1});
        tail_mod = (tail_mod + 1) % DEPTH;
        if (i2v) begin
          model_q.push_back('{pc + 32'd4, i2});
          tail_mod = (tail_mod + 1) % DEPTH;
        end
      end
    end
    #1;
    exp_q.push_back(snapshot());
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"}, 32'(count_o), 32'h0);
    chk({tag, "_ready"}, 32'(push_ready), 32'h1);
    chk({tag, "_v0"}, 32'(out0_valid), 32'h0);
    chk({tag, "_v1"}, 32'(out1_valid), 32'h0);
    chk({tag, "_pc0"}, out0_pc, 32'h0);
    chk({tag, "_inst0"}, out0_inst, 32'h0);
    chk({tag, "_pc1"}, out1_pc, 32'h0);
    chk({tag, "_inst1"}, out1_inst, 32'h0);
  endtask

  // Monitor: compare DUT outputs against the oldest pending expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      txn++;
      chk("count", 32'(count_o), 32'(e.cnt));
      chk("push_ready", 32'(push_ready), 32'(e.rdy));
      chk("out0_valid", 32'(out0_valid), 32'(e.v0));
      chk("out0_pc", out0_pc, e.pc0);
      chk("out0_inst", out0_inst, e.i0);
      chk("out1_valid", 32'(out1_valid), 32'(e.v1));
      chk("out1_pc", out1_pc, e.pc1);
      chk("out1_inst", out1_inst, e.i1);
      $display("txn %0d: count=%0d rdy=%0b out0=%0b/%h/%h out1=%0b/%h/%h", txn, count_o,
               push_ready, out0_valid, out0_pc, out0_inst, out1_valid, out1_pc, out1_inst);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pcv;
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Two-entry push after reset
    step(0, 1, 32'h8000_0000, 32'hAAAA_0001, 32'hBBBB_0002, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Fill with single pushes until full, then one ignored push
    pcv = 32'h1000_0000;
    while (model_q.size() < DEPTH - 1) begin
      step(0, 1, pcv, pcv ^ 32'h5A5A_0000, 32'hDEAD_BEEF, 0, 0);
      pcv += 32'd4;
    end
    step(0, 1, 32'hFFFF_FFF0, 32'h1234_5678, 32'h8765_4321, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Drain to 3, then simultaneous push-2/pop-2, then over-pop
    while (model_q.size() > 3) step(0, 0, 0, 0, 0, 0, (model_q.size() - 3 >= 2) ? 2'd2 : 2'd1);
    step(0, 1, 32'h2000_0000, 32'hC0DE_0001, 32'hC0DE_0002, 1, 2);
    while (model_q.size() > 1) step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 2);
    step(0, 0, 0, 0, 0, 0, 3);

    // Walk the tail to DEPTH-1 with an empty queue, then push a pair across the wrap
    while (tail_mod != DEPTH - 1 || model_q.size() != 0)
      step(0, tail_mod != DEPTH - 1, 32'h3000_0000 + 32'(tail_mod * 16), 32'h7700_0000 + 32'(tail_mod),
           0, 0, 2);
    step(0, 1, 32'hFFFF_FFFC, 32'hAAAA_7777, 32'hBBBB_0000, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Flush at count 5 with a concurrent push and pop
    while (model_q.size() < 5)
      step(0, 1, 32'h4000_0000 + 32'(model_q.size() * 8), 32'h4400_0000 + 32'(model_q.size()),
           32'h4800_0000, model_q.size() <= 3, 0);
    while (model_q.size() > 5) step(0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 32'h5000_0000, 32'h5555_5555, 32'h6666_6666, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a push
    step(0, 1, 32'h6000_0000, 32'h6100_0000, 32'h6200_0000, 1, 0);
    @(negedge clk);
    #2;
    flush = 0; push_valid = 1; push_pc = 32'h7000_0000; push_inst = 32'h7100_0000;
    push_inst2 = 32'h7200_0000; push_inst2_v = 1; pop_cnt = 0;
    #1 rst = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(posedge clk);
    #1 check_reset_outputs("rst_held");
    model_q.delete();
    tail_mod = 0;
    @(negedge clk);
    push_valid = 0;
    rst = 1'b1;
    step(0, 1, 32'h9000_0000, 32'h9100_0000, 32'h9200_0000, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, $urandom, $urandom, $urandom,
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
